instr_word_encoder: RTL and testbench

//  Encoder counterpart of the main control decoder. Accepts symbolic instructions (mnemonic + fields)

---
 rtl/mips_isa_pkg.sv | 51 +++++
 rtl/instr_word_pack.sv | 40 ++++
 rtl/instr_word_encoder.sv | 179 +++++++++++++++++
 tb/tb_instr_word_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg
//   Shared MIPS encoding constants for the instruction-word encoder.
//   Contents: field widths, primary opcodes (OP_RTYPE..OP_JAL),
//   the op_sel enumeration, and the encoder FSM state type.
package mips_isa_pkg;

    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;
    localparam int WORD_W  = 32;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    // Codes 12..15 are deliberately left out: they are the illegal selectors.
    typedef enum logic [3:0] {
        SEL_R    = 4'd0,
        SEL_LUI  = 4'd1,
        SEL_ADDI = 4'd2,
        SEL_ANDI = 4'd3,
        SEL_ORI  = 4'd4,
        SEL_XORI = 4'd5,
        SEL_LW   = 4'd6,
        SEL_SW   = 4'd7,
        SEL_BEQ  = 4'd8,
        SEL_BNE  = 4'd9,
        SEL_J    = 4'd10,
        SEL_JAL  = 4'd11
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DONE   = 2'd2,
        ST_VERIFY = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instr_word_pack.sv
// instr_word_pack
//   Combinational packer: op_sel + instruction fields -> 32-bit MIPS word.
//   Ports: op_sel_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm16_i, target26_i (in);
//          word_o (encoded word), legal_o (0 for op_sel 12..15, word_o = 0).
module instr_word_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]         op_sel_i,
    input  logic [REG_W-1:0]   rs_i,
    input  logic [REG_W-1:0]   rt_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [IMM_W-1:0]   imm16_i,
    input  logic [TGT_W-1:0]   target26_i,
    output logic [WORD_W-1:0]  word_o,
    output logic               legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (op_sel_i)
            SEL_R:    word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
            SEL_LUI:  word_o = {OP_LUI, {REG_W{1'b0}}, rt_i, imm16_i}; // rs is don't-care for LUI, force 0
            SEL_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm16_i};
            SEL_ANDI: word_o = {OP_ANDI, rs_i, rt_i, imm16_i};
            SEL_ORI:  word_o = {OP_ORI,  rs_i, rt_i, imm16_i};
            SEL_XORI: word_o = {OP_XORI, rs_i, rt_i, imm16_i};
            SEL_LW:   word_o = {OP_LW,   rs_i, rt_i, imm16_i};
            SEL_SW:   word_o = {OP_SW,   rs_i, rt_i, imm16_i};
            SEL_BEQ:  word_o = {OP_BEQ,  rs_i, rt_i, imm16_i};
            SEL_BNE:  word_o = {OP_BNE,  rs_i, rt_i, imm16_i};
            SEL_J:    word_o = {OP_J,   target26_i};
            SEL_JAL:  word_o = {OP_JAL, target26_i};
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_word_encoder.sv
// instr_word_encoder
//   Accepts symbolic instructions over valid/ready, packs them into MIPS words
//   and writes them sequentially into instruction memory (1 word/cycle, latency 1).
//   Ports: clk, rst_n (async low); start_i/finish_i session control;
//          in_valid_i/in_ready_o handshake with op_sel_i + field inputs;
//          mem_we_o/mem_addr_o/mem_wdata_o memory write; count_o, busy_o,
//          full_o, err_unknown_o status.
//   Optional: `define READBACK_VERIFY_EN adds mem_re_o, mem_rdata_i, verify_err_o
//   and a VERIFY state that reads back every written word (1 word/3 cycles).
module instr_word_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               finish_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [3:0]         op_sel_i,
    input  logic [REG_W-1:0]   rs_i,
    input  logic [REG_W-1:0]   rt_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [IMM_W-1:0]   imm16_i,
    input  logic [TGT_W-1:0]   target26_i,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [WORD_W-1:0]  mem_wdata_o,
`ifdef READBACK_VERIFY_EN
    output logic               mem_re_o,
    input  logic [WORD_W-1:0]  mem_rdata_i,
    output logic               verify_err_o,
`endif
    output logic [ADDR_W:0]    count_o,
    output logic               busy_o,
    output logic               full_o,
    output logic               err_unknown_o
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    enc_state_e          state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     count_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                we_q, full_q, err_q;
    logic [WORD_W-1:0]   word;
    logic                legal, hs, fills;
    logic [ADDR_W:0]     count_inc;

    instr_word_pack u_pack (
        .op_sel_i   (op_sel_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .rd_i       (rd_i),
        .shamt_i    (shamt_i),
        .funct_i    (funct_i),
        .imm16_i    (imm16_i),
        .target26_i (target26_i),
        .word_o     (word),
        .legal_o    (legal)
    );

    assign count_inc = count_q + CNT_ONE;
    // The write in flight this cycle is the one that fills memory; refuse new
    // fields now so nothing is accepted beyond DEPTH.
    assign fills      = we_q && (count_inc == DEPTH_C);
    assign in_ready_o = (state_q == ST_LOAD) && !full_q && !fills;
    assign hs         = in_valid_i && in_ready_o;

`ifdef READBACK_VERIFY_EN
    logic re_q, cmp_q, fin_q, verr_q;
    assign mem_re_o     = re_q;
    assign verify_err_o = verr_q;
    assign busy_o       = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
`else
    assign busy_o       = (state_q == ST_LOAD);
`endif

    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign count_o       = count_q;
    assign full_o        = full_q;
    assign err_unknown_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_C;
            count_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef READBACK_VERIFY_EN
            re_q    <= 1'b0;
            cmp_q   <= 1'b0;
            fin_q   <= 1'b0;
            verr_q  <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            // Retire the write issued last cycle; the address saturates on the
            // last slot so it never wraps past the end of memory.
            if (we_q) begin
                count_q <= count_inc;
                if (count_inc == DEPTH_C) full_q <= 1'b1;
`ifndef READBACK_VERIFY_EN
                else                      addr_q <= addr_q + ADR_ONE;
`else
                re_q <= 1'b1;
`endif
            end
`ifdef READBACK_VERIFY_EN
            // Read-back address is the just-written one, so advance after the read.
            if (re_q) begin
                re_q  <= 1'b0;
                cmp_q <= 1'b1;
                if (!full_q) addr_q <= addr_q + ADR_ONE;
            end
            if (cmp_q) begin
                cmp_q <= 1'b0;
                if (mem_rdata_i != wdata_q) verr_q <= 1'b1;
            end
`endif
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q <= ST_LOAD;
                        addr_q  <= BASE_C;
                        count_q <= '0;
                        full_q  <= 1'b0;
                        err_q   <= 1'b0;
`ifdef READBACK_VERIFY_EN
                        verr_q  <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        if (legal) begin
                            we_q    <= 1'b1;
                            wdata_q <= word;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
`ifdef READBACK_VERIFY_EN
                    if (hs && legal) begin
                        state_q <= ST_VERIFY;
                        fin_q   <= finish_i;
                    end else if (finish_i) begin
                        state_q <= ST_DONE;
                    end
`else
                    if (finish_i || fills) state_q <= ST_DONE;
`endif
                end
`ifdef READBACK_VERIFY_EN
                ST_VERIFY: begin
                    if (finish_i) fin_q <= 1'b1;
                    if (re_q) state_q <= (full_q || fin_q || finish_i) ? ST_DONE : ST_LOAD;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
module tb_instr_word_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        op_sel = '0;
    logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]        funct = '0;
    logic [15:0]       imm16 = '0;
    logic [25:0]       target26 = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy, full, err_unknown;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t exp_q[$];
    logic [ADDR_W-1:0] m_addr = '0;

    logic [5:0] opc_tab [12] = '{6'h00, 6'h0F, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    always #5 clk = ~clk;

    instr_word_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .finish_i     (finish),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .op_sel_i     (op_sel),
        .rs_i         (rs),
        .rt_i         (rt),
        .rd_i         (rd),
        .shamt_i      (shamt),
        .funct_i      (funct),
        .imm16_i      (imm16),
        .target26_i   (target26),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .count_o      (count),
        .busy_o       (busy),
        .full_o       (full),
        .err_unknown_o(err_unknown)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoding built with shifts from an opcode table.
    function automatic logic [31:0] model_enc(input logic [3:0] op, input logic [4:0] frs, frt, frd, fsh,
                                              input logic [5:0] ffn, input logic [15:0] fimm,
                                              input logic [25:0] ftgt);
        logic [31:0] w;
        logic [31:0] opw;
        opw = {26'd0, opc_tab[op]} << 26;
        if (op == 4'd0)
            w = ({27'd0, frs} << 21) | ({27'd0, frt} << 16) | ({27'd0, frd} << 11)
              | ({27'd0, fsh} << 6) | {26'd0, ffn};
        else if (op >= 4'd10)
            w = opw | {6'd0, ftgt};
        else
            w = opw | ((op == 4'd1) ? 32'd0 : ({27'd0, frs} << 21)) | ({27'd0, frt} << 16) | {16'd0, fimm};
        return w;
    endfunction

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {56'd0, mem_addr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {56'd0, mem_addr}, {56'd0, e.addr});
                chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
            end
        end
    end

    task automatic set_fields(input logic [3:0] op, input logic [4:0] frs, frt, frd, fsh,
                              input logic [5:0] ffn, input logic [15:0] fimm, input logic [25:0] ftgt);
        op_sel = op; rs = frs; rt = frt; rd = frd; shamt = fsh;
        funct = ffn; imm16 = fimm; target26 = ftgt;
    endtask

    // Called at a negedge; returns at the negedge following the handshake.
    task automatic send(input logic [3:0] op, input logic [4:0] frs, frt, frd, fsh,
                        input logic [5:0] ffn, input logic [15:0] fimm, input logic [25:0] ftgt,
                        input bit fin);
        int n;
        set_fields(op, frs, frt, frd, fsh, ffn, fimm, ftgt);
        in_valid = 1'b1;
        finish = fin;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("hs_timeout", {63'd0, in_ready}, 64'd1);
        end else if (op < 4'd12) begin
            exp_q.push_back('{m_addr, model_enc(op, frs, frt, frd, fsh, ffn, fimm, ftgt)});
            m_addr++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_addr = '0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_we",    {63'd0, mem_we}, 64'd0);
        chk("rst_rdy",   {63'd0, in_ready}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_full",  {63'd0, full}, 64'd0);
        chk("rst_err",   {63'd0, err_unknown}, 64'd0);
        chk("rst_addr",  {56'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_count", {55'd0, count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Session 1: single ADDI.
        pulse_start();
        chk("s1_busy", {63'd0, busy}, 64'd1);
        chk("s1_rdy",  {63'd0, in_ready}, 64'd1);
        send(4'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
        chk("s1_wdata_lit", {32'd0, mem_wdata}, 64'h20220005);
        @(negedge clk);
        chk("s1_count", {55'd0, count}, 64'd1);
        chk("s1_addr",  {56'd0, mem_addr}, 64'd1);

        // Session 2: R then LUI back-to-back.
        pulse_finish();
        chk("s1_done_busy", {63'd0, busy}, 64'd0);
        pulse_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
        send(4'd1, 5'd9, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
        chk("s2_lui_lit", {32'd0, mem_wdata}, 64'h3C041234);
        @(negedge clk);
        chk("s2_count", {55'd0, count}, 64'd2);

        // Session 3: JAL, then an illegal selector.
        pulse_finish();
        pulse_start();
        send(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 1'b0);
        chk("s3_jal_lit", {32'd0, mem_wdata}, 64'h0C000010);
        send(4'hF, 5'd1, 5'd2, 5'd3, 5'd4, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        @(negedge clk);
        chk("s3_err",   {63'd0, err_unknown}, 64'd1);
        chk("s3_count", {55'd0, count}, 64'd1);
        chk("s3_addr",  {56'd0, mem_addr}, 64'd1);

        // Session 4: fill all DEPTH slots with mixed ops.
        pulse_finish();
        pulse_start();
        chk("s4_err_clr", {63'd0, err_unknown}, 64'd0);
        send(4'd6, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b0);
        send(4'd7, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
        send(4'd8, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h8001, 26'd0, 1'b0);
        send(4'd5, 5'd31, 5'd31, 5'd0, 5'd0, 6'd0, 16'hA5A5, 26'd0, 1'b0);
        set_fields(4'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
        in_valid = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            if (in_ready) seen = 1'b1;
            @(negedge clk);
        end
        chk("s4_no_5th", {63'd0, seen}, 64'd0);
        in_valid = 1'b0;
        chk("s4_full",  {63'd0, full}, 64'd1);
        chk("s4_busy",  {63'd0, busy}, 64'd0);
        chk("s4_count", {55'd0, count}, 64'd4);
        chk("s4_addr",  {56'd0, mem_addr}, 64'd3);

        // start together with in_valid in DONE: start only.
        in_valid = 1'b1;
        start = 1'b1;
        chk("st_iv_rdy", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        m_addr = '0;
        chk("st_iv_count", {55'd0, count}, 64'd0);
        chk("st_iv_full",  {63'd0, full}, 64'd0);
        chk("st_iv_rdy2",  {63'd0, in_ready}, 64'd1);

        // finish together with a handshake: word written, then DONE.
        send(4'd4, 5'd7, 5'd6, 5'd0, 5'd0, 6'd0, 16'h00F0, 26'd0, 1'b1);
        @(negedge clk);
        chk("fin_busy",  {63'd0, busy}, 64'd0);
        chk("fin_count", {55'd0, count}, 64'd1);

        // Reset during the pending-write cycle drops the write.
        pulse_start();
        set_fields(4'd3, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_mid_we", {63'd0, mem_we}, 64'd0);
        @(negedge clk);
        chk("rst_mid_count", {55'd0, count}, 64'd0);
        chk("rst_mid_busy",  {63'd0, busy}, 64'd0);
        chk("rst_mid_addr",  {56'd0, mem_addr}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h2ABCDEF, 1'b0);
        @(negedge clk);
        chk("restart_count", {55'd0, count}, 64'd1);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
